sample_clk_gen: RTL and testbench

- Parametrised, runtime-programmable sample-clock generator for the receiver datapath.
- Successor to the fixed-ratio slow sample clock: it adds a loadable divisor, enable, phase realignment, and single-cycle rise, fall and mid-high strobes.
- Sits between the system clock and the photodiode sampler and bit-recovery logic.
- Downstream logic uses the strobes as clock enables and never clocks flops on new_clock directly.

---
 rtl/sample_clk_gen_pkg.sv | 6 +
 rtl/sample_clk_gen_div_counter.sv | 19 +
 rtl/sample_clk_gen.sv | 57 +++++
 tb/tb_sample_clk_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sample_clk_gen_pkg.sv
// sample_clk_gen_pkg: shared receiver constants for the sample-clock generator
package sample_clk_gen_pkg;
  localparam int RX_CNT_W = 22;
  localparam int RX_DEFAULT_HALF = 6;
  localparam logic RESET_ACTIVE = 1'b0;
endpackage

// File: rtl/sample_clk_gen_div_counter.sv
// div_counter: half-period counter with terminal-count compare, sync clear and hold
//   clock, reset (async, active-low); clear: sync clear to 0 (priority); run: 0 = hold
//   limit: terminal count; count: current value; tc: count == limit
module div_counter import sample_clk_gen_pkg::*; #(
  parameter int CNT_W = RX_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);
  assign tc = count == limit;
  always_ff @(posedge clock or negedge reset)
    if (reset == RESET_ACTIVE) count <= '0;
    else count <= clear ? '0 : !run ? count : tc ? '0 : count + CNT_W'(1);
endmodule

// File: rtl/sample_clk_gen.sv
// sample_clk_gen: programmable divided sample clock with rise/fall/mid-high strobes
//   clock, reset (async, active-low); enable: 1 = run, 0 = freeze
//   div_load/div_value: request a new half-period divisor; div_busy: load pending
//   phase_align: restart from low phase with counter 0
//   new_clock: divided clock; rise/fall/mid_strobe: one-cycle enables; half_div: divisor in effect
module sample_clk_gen import sample_clk_gen_pkg::*; #(
  parameter int CNT_W = RX_CNT_W,
  parameter int DEFAULT_HALF = RX_DEFAULT_HALF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_busy,
  input  logic             phase_align,
  output logic             new_clock,
  output logic             rise_strobe,
  output logic             fall_strobe,
  output logic             mid_strobe,
  output logic [CNT_W-1:0] half_div
);
  logic [CNT_W-1:0] count, pending;
  logic tc, run, wrap, apply;
  assign run = enable && !phase_align;
  assign wrap = run && tc;
  // a pending divisor only takes effect at the high-to-low wrap, where the counter restarts at 0
  assign apply = wrap && new_clock && div_busy;
  div_counter #(.CNT_W(CNT_W)) u_div_counter (
    .clock(clock),
    .reset(reset),
    .clear(phase_align),
    .run(enable),
    .limit(half_div),
    .count(count),
    .tc(tc)
  );
  always_ff @(posedge clock or negedge reset)
    if (reset == RESET_ACTIVE) begin
      new_clock <= 1'b0;
      rise_strobe <= 1'b0;
      fall_strobe <= 1'b0;
      mid_strobe <= 1'b0;
      half_div <= CNT_W'(DEFAULT_HALF);
      pending <= '0;
      div_busy <= 1'b0;
    end else begin
      new_clock <= !phase_align && (wrap ? !new_clock : new_clock);
      rise_strobe <= wrap && !new_clock;
      fall_strobe <= wrap && new_clock;
      // with a one-cycle high phase the centre is the rise cycle itself
      mid_strobe <= run && (half_div == '0 ? tc && !new_clock : new_clock && count == half_div >> 1);
      half_div <= phase_align ? (div_load ? div_value : div_busy ? pending : half_div) : apply ? pending : half_div;
      pending <= div_load ? div_value : pending;
      div_busy <= !phase_align && (div_load || (div_busy && !apply));
    end
endmodule

// File: tb/tb_sample_clk_gen.sv
// tb_sample_clk_gen: directed self-checking bench for sample_clk_gen
module tb_sample_clk_gen;
  localparam int CNT_W = 22;
  logic clock = 1'b0;
  logic reset, enable, div_load, phase_align;
  logic [CNT_W-1:0] div_value;
  logic div_busy, new_clock, rise_strobe, fall_strobe, mid_strobe;
  logic [CNT_W-1:0] half_div;
  int checks = 0;
  int failures = 0;
  int n, r, f, m, s, hc;
  sample_clk_gen dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .div_load(div_load),
    .div_value(div_value),
    .div_busy(div_busy),
    .phase_align(phase_align),
    .new_clock(new_clock),
    .rise_strobe(rise_strobe),
    .fall_strobe(fall_strobe),
    .mid_strobe(mid_strobe),
    .half_div(half_div)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clock);
  endtask
  // cycles until the selected strobe (0 rise, 1 fall, 2 mid) is seen; -1 on timeout
  task automatic wait_ev(input int sel, output int cnt);
    cnt = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (sel == 0 ? rise_strobe : sel == 1 ? fall_strobe : mid_strobe) begin
        cnt = i;
        break;
      end
    end
  endtask
  initial begin
    reset = 1'b0;
    enable = 1'b0;
    div_load = 1'b0;
    phase_align = 1'b0;
    div_value = '0;
    tick(3);
    check("rst_clk", new_clock, 0);
    check("rst_str", {rise_strobe, fall_strobe, mid_strobe}, 0);
    check("rst_half", half_div, 6);
    check("rst_busy", div_busy, 0);
    reset = 1'b1;
    enable = 1'b1;
    wait_ev(0, n); check("first_rise", n, 7);
    check("rise_clk", new_clock, 1);
    wait_ev(2, n); check("mid_after_rise", n, 4);
    wait_ev(1, n); check("fall_after_mid", n, 3);
    wait_ev(0, n); check("low_len", n, 7);
    r = 0; f = 0; m = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      r += int'(rise_strobe); f += int'(fall_strobe); m += int'(mid_strobe);
    end
    check("win_rise", r, 1);
    check("win_fall", f, 1);
    check("win_mid", m, 1);
    tick(2);
    div_load = 1'b1; div_value = 2;
    tick(1);
    div_load = 1'b0;
    check("load_busy", div_busy, 1);
    check("load_half_old", half_div, 6);
    wait_ev(1, n); check("load_fall", n, 4);
    check("load_busy_clr", div_busy, 0);
    check("load_half_new", half_div, 2);
    wait_ev(0, n); check("d2_low", n, 3);
    wait_ev(1, n); check("d2_high", n, 3);
    div_load = 1'b1; div_value = 9;
    tick(1);
    div_value = 1;
    tick(1);
    div_load = 1'b0;
    wait_ev(1, n); check("two_fall", n, 4);
    check("two_half", half_div, 1);
    check("two_busy", div_busy, 0);
    wait_ev(0, n); check("d1_low", n, 2);
    wait_ev(1, n); check("d1_high", n, 2);
    div_load = 1'b1; div_value = 5;
    tick(1);
    div_load = 1'b0;
    tick(2);
    div_load = 1'b1; div_value = 3;
    tick(1);
    div_load = 1'b0;
    check("coin_fall", fall_strobe, 1);
    check("coin_half", half_div, 5);
    check("coin_busy", div_busy, 1);
    wait_ev(1, n); check("coin_period", n, 12);
    check("coin_half2", half_div, 3);
    check("coin_busy2", div_busy, 0);
    tick(1);
    enable = 1'b0;
    s = 0; hc = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      s += int'(rise_strobe) + int'(fall_strobe) + int'(mid_strobe);
      hc += int'(new_clock);
      if (i == 1) begin div_load = 1'b1; div_value = 6; end
      if (i == 2) div_load = 1'b0;
    end
    check("dis_strobes", s, 0);
    check("dis_clk", hc, 0);
    check("dis_busy", div_busy, 1);
    check("dis_half", half_div, 3);
    enable = 1'b1;
    wait_ev(0, n); check("resume_rise", n, 3);
    wait_ev(1, n); check("resume_fall", n, 4);
    check("dis_load_half", half_div, 6);
    wait_ev(0, n); check("d6_low", n, 7);
    tick(4);
    check("pa_pre_clk", new_clock, 1);
    phase_align = 1'b1;
    tick(1);
    phase_align = 1'b0;
    check("pa_clk", new_clock, 0);
    check("pa_nostrobe", {rise_strobe, fall_strobe}, 0);
    wait_ev(0, n); check("pa_rise", n, 7);
    phase_align = 1'b1; div_load = 1'b1; div_value = 4;
    tick(1);
    phase_align = 1'b0; div_load = 1'b0;
    check("pald_half", half_div, 4);
    check("pald_busy", div_busy, 0);
    check("pald_clk", new_clock, 0);
    wait_ev(0, n); check("pald_rise", n, 5);
    wait_ev(2, n); check("d4_mid", n, 3);
    phase_align = 1'b1; div_load = 1'b1; div_value = 0;
    tick(1);
    phase_align = 1'b0; div_load = 1'b0;
    check("d0_half", half_div, 0);
    tick(1);
    check("d0_rise", {new_clock, rise_strobe, mid_strobe}, 3'b111);
    tick(1);
    check("d0_fall", {new_clock, fall_strobe, mid_strobe}, 3'b010);
    phase_align = 1'b1; div_load = 1'b1; div_value = 5;
    tick(1);
    phase_align = 1'b0; div_load = 1'b0;
    tick(1);
    div_load = 1'b1; div_value = 9;
    tick(1);
    div_load = 1'b0;
    wait_ev(0, n); check("d5_rise", n, 4);
    check("pre_rst_busy", div_busy, 1);
    tick(2);
    check("pre_rst_clk", new_clock, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_clk", new_clock, 0);
    check("arst_str", {rise_strobe, fall_strobe, mid_strobe}, 0);
    check("arst_busy", div_busy, 0);
    check("arst_half", half_div, 6);
    tick(2);
    reset = 1'b1;
    wait_ev(0, n); check("post_rst_rise", n, 7);
    wait_ev(1, n); check("post_rst_fall", n, 7);
    check("post_rst_half", half_div, 6);
    check("post_rst_busy", div_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
